// File: rtl/slow_launch_pkg.sv
// Shared definitions for the slow-to-fast CDC launcher: FSM encodings and default timing.
// Sampler-side benches import the same defaults so both ends agree on pulse shape.
package slow_launch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_HOLD = 2'd2,
      ST_BAD  = 2'd3
   } state_e;

   localparam int DEF_DW      = 32;
   localparam int DEF_EN_HIGH = 2;
   localparam int DEF_GAP     = 2;
   localparam int CNT_W       = 16;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/slow_launch.sv
// Source-domain launcher: accepts a word on valid/ready, then drives din with a stretched
// din_en pulse followed by a low gap so a 2-flop sync plus edge detect in clk2 sees it once.
module slow_launch
   import slow_launch_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int EN_HIGH = DEF_EN_HIGH,
   parameter int GAP     = DEF_GAP
) (
   input  logic              clk1,
   input  logic              rstn,
   input  logic              s_valid,
   input  logic [DW-1:0]     s_data,
   output logic              s_ready,
   output logic [DW-1:0]     din,
   output logic              din_en,
   output logic              busy,
   output logic [CNT_W-1:0]  word_cnt
);

   localparam int TW = $clog2(max2(EN_HIGH, GAP) + 1);

   generate
      if (EN_HIGH < 1 || GAP < 1 || (EN_HIGH + GAP) < 3) begin : g_bad_params
         $error("slow_launch: need EN_HIGH>=1, GAP>=1 and EN_HIGH+GAP>=3");
      end
   endgenerate

   state_e              state_q;
   logic [TW-1:0]       tmr_q;
   logic [TW-1:0]       tmr_d;
   logic [DW-1:0]       din_q;
   logic                din_en_q;
   logic [CNT_W-1:0]    word_cnt_q;
   logic [CNT_W-1:0]    word_cnt_d;

   assign tmr_d      = tmr_q - 1'b1;
   assign word_cnt_d = word_cnt_q + 1'b1;

   // Ready depends on state alone so upstream never sees a comb path from s_valid.
   assign s_ready  = (state_q == ST_IDLE);
   assign busy     = (state_q != ST_IDLE);
   assign din      = din_q;
   assign din_en   = din_en_q;
   assign word_cnt = word_cnt_q;

   always_ff @(posedge clk1) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         tmr_q      <= '0;
         din_q      <= '0;
         din_en_q   <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               din_en_q <= 1'b0;
               if (s_valid) begin
                  din_q      <= s_data;
                  din_en_q   <= 1'b1;
                  word_cnt_q <= word_cnt_d;
                  tmr_q      <= TW'(EN_HIGH - 1);
                  state_q    <= ST_HIGH;
               end
            end
            ST_HIGH: begin
               if (tmr_q == '0) begin
                  din_en_q <= 1'b0;
                  tmr_q    <= TW'(GAP - 1);
                  state_q  <= ST_HOLD;
               end else begin
                  tmr_q <= tmr_d;
               end
            end
            ST_HOLD: begin
               din_en_q <= 1'b0;
               if (tmr_q == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  tmr_q <= tmr_d;
               end
            end
            default: begin
               state_q  <= ST_IDLE;
               din_en_q <= 1'b0;
               tmr_q    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slow_launch.sv
// Bench for slow_launch: constant tables, hand sequences and random traffic against an
// age-since-accept reference model.
module tb_slow_launch;
   import slow_launch_pkg::*;

   localparam int EN_HIGH  = DEF_EN_HIGH;
   localparam int GAP      = DEF_GAP;
   localparam int IDLE_AGE = EN_HIGH + GAP;

   logic        clk1 = 1'b0;
   logic        rstn = 1'b0;
   logic        s_valid = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_ready;
   logic [31:0] din;
   logic        din_en;
   logic        busy;
   logic [15:0] word_cnt;

   slow_launch #(.DW(32), .EN_HIGH(EN_HIGH), .GAP(GAP)) dut (
      .clk1     (clk1),
      .rstn     (rstn),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_ready  (s_ready),
      .din      (din),
      .din_en   (din_en),
      .busy     (busy),
      .word_cnt (word_cnt)
   );

   always #5 clk1 = ~clk1;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: cycles elapsed since the last accepted word.
   int          m_age = IDLE_AGE;
   logic [31:0] m_din = '0;
   logic [15:0] m_cnt = '0;
   logic        last_acc;

   typedef struct {
      logic        v;
      logic [31:0] d;
      logic [31:0] din;
      logic        en;
      logic        rdy;
      logic [15:0] cnt;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic rst_n, input logic v, input logic [31:0] d);
      rstn     = rst_n;
      s_valid  = v;
      s_data   = d;
      last_acc = rst_n && v && (m_age >= IDLE_AGE);
      @(posedge clk1);
      cyc++;
      if (!rst_n) begin
         m_age = IDLE_AGE; m_din = '0; m_cnt = '0;
      end else if (last_acc) begin
         m_age = 0; m_din = d; m_cnt = m_cnt + 16'd1;
      end else if (m_age < IDLE_AGE) begin
         m_age++;
      end
      #1;
      chk("model_din", din, m_din);
      chk("model_din_en", 32'(din_en), 32'(m_age < EN_HIGH));
      chk("model_s_ready", 32'(s_ready), 32'(m_age >= IDLE_AGE));
      chk("model_busy", 32'(busy), 32'(m_age < IDLE_AGE));
      chk("model_word_cnt", 32'(word_cnt), 32'(m_cnt));
   endtask

   task automatic do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hFFFF_FFFF);
      chk("reset_din", din, 32'h0);
      chk("reset_din_en", 32'(din_en), 32'h0);
      chk("reset_s_ready", 32'(s_ready), 32'h1);
      chk("reset_word_cnt", 32'(word_cnt), 32'h0);
   endtask

   initial begin
      vec_t tbl[11];
      logic [31:0] words[3];
      int acc_cyc[3];
      int idx;
      logic [31:0] tog;

      tbl[0]  = '{1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 16'd1};
      tbl[1]  = '{1'b0, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 16'd1};
      tbl[2]  = '{1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 16'd1};
      tbl[3]  = '{1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 16'd1};
      tbl[4]  = '{1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 16'd1};
      tbl[5]  = '{1'b1, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 1'b0, 16'd2};
      tbl[6]  = '{1'b1, 32'h11111111, 32'h0BADF00D, 1'b1, 1'b0, 16'd2};
      tbl[7]  = '{1'b1, 32'h22222222, 32'h0BADF00D, 1'b0, 1'b0, 16'd2};
      tbl[8]  = '{1'b1, 32'h22222222, 32'h0BADF00D, 1'b0, 1'b0, 16'd2};
      tbl[9]  = '{1'b1, 32'h33333333, 32'h0BADF00D, 1'b0, 1'b1, 16'd2};
      tbl[10] = '{1'b1, 32'h33333333, 32'h33333333, 1'b1, 1'b0, 16'd3};

      do_reset();

      for (int i = 0; i < 11; i++) begin
         step(1'b1, tbl[i].v, tbl[i].d);
         chk($sformatf("tbl%0d_din", i), din, tbl[i].din);
         chk($sformatf("tbl%0d_en", i), 32'(din_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_rdy", i), 32'(s_ready), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_cnt", i), 32'(word_cnt), 32'(tbl[i].cnt));
      end

      // Back-to-back with s_valid held high.
      do_reset();
      words = '{32'h1, 32'h2, 32'h3};
      idx = 0;
      for (int n = 0; n < 40 && idx < 3; n++) begin
         step(1'b1, 1'b1, words[idx]);
         if (last_acc) begin
            chk("b2b_din", din, words[idx]);
            acc_cyc[idx] = cyc;
            idx++;
         end
      end
      chk("b2b_accepted_all", 32'(idx), 32'd3);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0);
      chk("b2b_word_cnt", 32'(word_cnt), 32'd3);
      if (idx == 3) begin
         chk("b2b_spacing01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
         chk("b2b_spacing12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
      end

      // Data toggling while busy must not disturb din.
      step(1'b1, 1'b1, 32'hAAAA5555);
      tog = 32'h5555AAAA;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, tog);
         chk("toggle_din_held", din, 32'hAAAA5555);
         tog = ~tog;
      end
      step(1'b1, 1'b0, 32'h0);

      // Reset on the second din_en-high cycle.
      step(1'b1, 1'b1, 32'hCAFEF00D);
      step(1'b1, 1'b0, 32'h0);
      chk("midrst_pre_en", 32'(din_en), 32'h1);
      step(1'b0, 1'b0, 32'h0);
      chk("midrst_din_en", 32'(din_en), 32'h0);
      chk("midrst_din", din, 32'h0);
      chk("midrst_s_ready", 32'(s_ready), 32'h1);
      chk("midrst_word_cnt", 32'(word_cnt), 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), $urandom);
      end
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);

      // Counter wrap: preload 0xFFFF while idle, then send one word.
      force dut.word_cnt_q = 16'hFFFF;
      #1;
      release dut.word_cnt_q;
      m_cnt = 16'hFFFF;
      step(1'b1, 1'b0, 32'h0);
      chk("wrap_preload", 32'(word_cnt), 32'hFFFF);
      step(1'b1, 1'b1, 32'h12345678);
      chk("wrap_word_cnt", 32'(word_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
